// File: rtl/bram_sdp_be_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_sdp_be_if
// Brief    : Port bundle for the byte-enable simple dual-port RAM
//            (port-A write, port-B read, init status).
// Revision : 1.0 - initial release
// ============================================================================
interface bram_sdp_be_if #(
    parameter int RAM_WIDTH = 64,
    parameter int RAM_DEPTH = 512,
    parameter int BYTE_W    = 8
);
    localparam int c_NB = RAM_WIDTH / BYTE_W;
    localparam int c_AW = $clog2(RAM_DEPTH);

    logic                 wr_ena;
    logic [c_NB-1:0]      wea;
    logic [c_AW-1:0]      addra;
    logic [RAM_WIDTH-1:0] dina;
    logic                 rd_enb;
    logic [c_AW-1:0]      addrb;
    logic [RAM_WIDTH-1:0] doutb;
    logic                 doutb_valid;
    logic                 init_done;

    modport master (
        output wr_ena, wea, addra, dina, rd_enb, addrb,
        input  doutb, doutb_valid, init_done
    );

    modport slave (
        input  wr_ena, wea, addra, dina, rd_enb, addrb,
        output doutb, doutb_valid, init_done
    );
endinterface
`default_nettype wire

// File: rtl/bram_sdp_be.sv
`default_nettype none
// ============================================================================
// Module   : bram_sdp_be
// Brief    : Simple dual-port RAM with byte-lane writes, post-reset zero
//            sweep and 1- or 2-cycle read latency. Optional macro
//            BRAM_SDP_WR_BYPASS_EN turns same-address collisions write-first.
// Revision : 1.0 - initial release
// ============================================================================
module bram_sdp_be #(
    parameter int RAM_WIDTH  = 64,
    parameter int RAM_DEPTH  = 512,
    parameter int BYTE_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    bram_sdp_be_if.slave  bus
);
    localparam int c_NB = RAM_WIDTH / BYTE_W;
    localparam int c_AW = $clog2(RAM_DEPTH);
    localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(RAM_DEPTH);
    localparam logic [c_AW-1:0] c_LAST  = c_AW'(RAM_DEPTH - 1);

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("bram_sdp_be: RD_LATENCY must be 1 or 2");
        end
        if ((RAM_WIDTH % BYTE_W) != 0) begin : g_bad_width
            $error("bram_sdp_be: RAM_WIDTH must be a multiple of BYTE_W");
        end
        if (RAM_DEPTH < 2) begin : g_bad_depth
            $error("bram_sdp_be: RAM_DEPTH must be at least 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_AW-1:0]      r_sweep_addr;
    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];

    logic                 w_ready;
    logic                 w_wa_ok;
    logic                 w_rb_ok;
    logic                 w_wr_user;
    logic                 w_rd_acc;
    logic [c_NB-1:0]      w_we;
    logic [c_AW-1:0]      w_waddr;
    logic [RAM_WIDTH-1:0] w_wdata;
    logic [RAM_WIDTH-1:0] w_rd_word;
    logic [RAM_WIDTH-1:0] r_dout;
    logic                 r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_sweep_addr == c_LAST) w_state_nxt = S_READY;
            S_READY: w_state_nxt = S_READY;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Sweep pointer only matters while clearing; its post-sweep value is don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep_addr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_sweep_addr <= r_sweep_addr + c_AW'(1);
        end
    end

    assign w_ready   = (r_state == S_READY);
    assign w_wa_ok   = ({1'b0, bus.addra} < c_DEPTH);
    assign w_rb_ok   = ({1'b0, bus.addrb} < c_DEPTH);
    assign w_wr_user = w_ready && bus.wr_ena && w_wa_ok;
    assign w_rd_acc  = w_ready && bus.rd_enb;

    always_comb begin
        w_we    = '0;
        w_waddr = bus.addra;
        w_wdata = bus.dina;
        if (!rst) begin
            if (!w_ready) begin
                w_we    = '1;
                w_waddr = r_sweep_addr;
                w_wdata = '0;
            end else if (w_wr_user) begin
                w_we    = bus.wea;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NB; i++) begin
            if (w_we[i]) begin
                r_mem[w_waddr][i*BYTE_W +: BYTE_W] <= w_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Array is sampled before this edge's write lands, so the default is read-first.
    always_comb begin
        w_rd_word = w_rb_ok ? r_mem[bus.addrb] : '0;
`ifdef BRAM_SDP_WR_BYPASS_EN
        for (int i = 0; i < c_NB; i++) begin
            if (w_wr_user && (bus.addra == bus.addrb) && bus.wea[i]) begin
                w_rd_word[i*BYTE_W +: BYTE_W] = bus.dina[i*BYTE_W +: BYTE_W];
            end
        end
`endif
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [RAM_WIDTH-1:0] r_p1_data;
            logic                 r_p1_vld;

            always_ff @(posedge clk) begin
                if (w_rd_acc) begin
                    r_p1_data <= w_rd_word;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_p1_vld <= 1'b0;
                    r_vld    <= 1'b0;
                    r_dout   <= '0;
                end else begin
                    r_p1_vld <= w_rd_acc;
                    r_vld    <= r_p1_vld;
                    if (r_p1_vld) begin
                        r_dout <= r_p1_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld  <= 1'b0;
                    r_dout <= '0;
                end else begin
                    r_vld <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_dout <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

    assign bus.doutb       = r_dout;
    assign bus.doutb_valid = r_vld;
    assign bus.init_done   = w_ready;

endmodule
`default_nettype wire
